// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
// Iterative AES encryption round controller. Accepts one 128-bit plaintext
// block, applies the initial AddRoundKey, then drives an external round unit
// once per round (SubBytes/ShiftRows/MixColumns, MixColumns skipped on the last
// round). AddRoundKey is applied to each round result here, and the ciphertext
// is returned through a valid/ready handshake.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     plaintext handshake, in_data (byte 0 at [127:120])
//   out_valid/out_ready   ciphertext handshake, out_data (0 when not valid)
//   rk_idx/rk             round-key index and same-cycle key from the key store
//   ru_req/ru_ack         round unit handshake
//   ru_last               current round is the final one (no MixColumns)
//   ru_state/ru_result    state to the round unit and its result
//   busy                  a block is in flight or waiting to be collected
module aes_round_sequencer #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         ru_req,
  output logic         ru_last,
  output logic [127:0] ru_state,
  input  logic         ru_ack,
  input  logic [127:0] ru_result,
  output logic         busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_sequencer: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] LastRnd = 4'(NR);

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;

  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    rk_idx    = '0;
    ru_req    = 1'b0;
    ru_last   = 1'b0;
    ru_state  = '0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Initial AddRoundKey with key 0 (rk_idx is 0 in this state).
          st_d    = in_data ^ rk;
          rnd_d   = 4'd1;
          state_d = StRound;
        end
      end
      StRound: begin
        busy     = 1'b1;
        ru_req   = 1'b1;
        ru_state = st_q;
        rk_idx   = rnd_q;
        ru_last  = (rnd_q == LastRnd);
        if (ru_ack) begin
          st_d = ru_result ^ rk;
          if (rnd_q == LastRnd) begin
            state_d = StDone;
          end else begin
            // ru_req stays high: the next round is requested straight away.
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = st_q;
        // in_ready stays low here, so a new block waits one cycle minimum.
        if (out_ready) begin
          state_d = StIdle;
          rnd_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      st_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;
  localparam int NR = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // NR=10 instance signals
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, out_data, rk, ru_state, ru_result;
  logic [3:0]   rk_idx;
  logic         ru_req, ru_last, ru_ack, busy;

  // NR=14 instance signals
  logic         in_valid14, in_ready14, out_valid14, out_ready14;
  logic [127:0] in_data14, out_data14, ru_state14;
  logic [3:0]   rk_idx14;
  logic         ru_req14, ru_last14, ru_ack14, busy14;

  // Stimulus controls
  bit       unit_mode;   // 0: identity, 1: byte rotate with last-round marker
  bit [1:0] key_mode;
  int       waits;
  bit       force_ack;
  bit       mon_en;
  int       wcnt;

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [127:0] keyf(input bit [1:0] m, input logic [3:0] i);
    if (m == 2'd1) return {16{i, 4'h0}};
    return '0;
  endfunction

  function automatic logic [127:0] unitf(input logic [127:0] s, input logic last);
    return {s[119:0], s[127:120]} ^ (last ? 128'h0 : 128'h1);
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input bit um,
                                         input bit [1:0] km, input int nr);
    logic [127:0] s;
    s = d ^ keyf(km, 4'd0);
    for (int r = 1; r <= nr; r++) begin
      s = (um ? unitf(s, r == nr) : s) ^ keyf(km, 4'(r));
    end
    return s;
  endfunction

  assign rk        = keyf(key_mode, rk_idx);
  assign ru_result = unit_mode ? unitf(ru_state, ru_last) : ru_state;
  assign ru_ack    = force_ack | (ru_req && wcnt == waits);

  assign ru_ack14 = ru_req14;

  aes_round_sequencer #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .rk_idx(rk_idx),
    .rk(rk), .ru_req(ru_req), .ru_last(ru_last), .ru_state(ru_state), .ru_ack(ru_ack),
    .ru_result(ru_result), .busy(busy)
  );

  aes_round_sequencer #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid14), .in_ready(in_ready14),
    .in_data(in_data14), .out_valid(out_valid14), .out_ready(out_ready14),
    .out_data(out_data14), .rk_idx(rk_idx14), .rk(128'h0), .ru_req(ru_req14),
    .ru_last(ru_last14), .ru_state(ru_state14), .ru_ack(ru_ack14),
    .ru_result(ru_state14), .busy(busy14)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference phase tracker for the NR=10 instance.
  int       ph;
  logic [3:0] exp_r;
  int       acks;
  always @(posedge clk) begin
    if (!ru_req || ru_ack || rst) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (rst) begin
      ph    <= 0;
      exp_r <= '0;
    end else begin
      case (ph)
        0: if (in_valid) begin ph <= 1; exp_r <= 4'd1; acks <= 0; end
        1: if (ru_ack) begin
             acks <= acks + 1;
             if (exp_r == 4'(NR)) ph <= 2;
             else exp_r <= exp_r + 4'd1;
           end
        2: if (out_ready) begin ph <= 0; exp_r <= '0; end
        default: ph <= 0;
      endcase
    end
  end

  // Per-cycle output checks against the tracker.
  bit           prev_wait;
  logic [127:0] prev_s;
  logic [3:0]   prev_i;
  always @(negedge clk) begin
    if (mon_en) begin
      chk1("mon_in_ready", in_ready, ph == 0);
      chk1("mon_busy", busy, ph != 0);
      chk1("mon_out_valid", out_valid, ph == 2);
      chk1("mon_ru_req", ru_req, ph == 1);
      if (ph == 0) chk("mon_rk_idx_idle", {124'h0, rk_idx}, 128'h0);
      if (ph == 1) chk("mon_rk_idx_seq", {124'h0, rk_idx}, {124'h0, exp_r});
      if (ph != 2) chk("mon_out_data_zero", out_data, 128'h0);
      if (ph != 1) chk("mon_ru_state_zero", ru_state, 128'h0);
      if (ph != 2) chk1("mon_ru_last", ru_last, ph == 1 && exp_r == 4'(NR));
      if (prev_wait && !rst && ph == 1) begin
        chk("mon_ru_state_hold", ru_state, prev_s);
        chk("mon_rk_idx_hold", {124'h0, rk_idx}, {124'h0, prev_i});
      end
    end
    prev_wait = (ph == 1) && !ru_ack && !rst;
    prev_s    = ru_state;
    prev_i    = rk_idx;
  end

  // Handshake counters for the NR=14 instance.
  int acks14, last14, badlast14;
  always @(posedge clk) begin
    if (rst) begin
      acks14 <= 0; last14 <= 0; badlast14 <= 0;
    end else begin
      if (ru_req14 && ru_ack14) begin
        acks14 <= acks14 + 1;
        if (ru_last14) last14 <= last14 + 1;
      end
      if (ru_last14 && rk_idx14 != 4'd14) badlast14 <= badlast14 + 1;
    end
  end

  typedef struct {
    bit           umode;
    bit [1:0]     kmode;
    int           nwait;
    logic [127:0] data;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[5];

  // Waits for out_valid; returns edges counted since the accept edge.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 300) begin
      step();
      n++;
    end
    if (!out_valid) begin
      n_vec++;
      n_bad++;
      $display("FAIL out_valid_timeout: got 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic run_block(input vec_t v, input bit release_out);
    int n;
    unit_mode = v.umode;
    key_mode  = v.kmode;
    waits     = v.nwait;
    in_data   = v.data;
    in_valid  = 1'b1;
    chk1("accept_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    in_data  = '0;
    wait_out(n);
    chk("latency", 128'(n), 128'(v.lat));
    chk("out_data", out_data, v.exp);
    chk("ack_count", 128'(acks), 128'(NR));
    if (release_out) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk1("released_in_ready", in_ready, 1'b1);
    end
  endtask

  initial begin
    int n;
    logic [127:0] y;
    vecs[0] = '{1'b0, 2'd0, 0, 128'h00112233445566778899aabbccddeeff,
                128'h00112233445566778899aabbccddeeff, 10};
    vecs[1] = '{1'b0, 2'd1, 0, 128'h0, {16{8'hb0}}, 10};
    vecs[2] = '{1'b0, 2'd1, 3, 128'h00112233445566778899aabbccddeeff,
                128'hb0a19283f4e5d6c738291a0b7c6d5e4f, 40};
    vecs[3] = '{1'b1, 2'd1, 1, 128'h0123456789abcdeffedcba9876543210, 128'h0, 20};
    vecs[3].exp = model(vecs[3].data, 1'b1, 2'd1, NR);
    vecs[4] = '{1'b0, 2'd0, 2, 128'hdeadbeef0badf00dcafebabe12345678,
                128'hdeadbeef0badf00dcafebabe12345678, 30};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid14 = 1'b0; in_data14 = '0; out_ready14 = 1'b0;
    unit_mode = 1'b0; key_mode = 2'd0; waits = 0; force_ack = 1'b0; mon_en = 1'b0;
    step();
    step();
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_ru_req", ru_req, 1'b0);
    chk1("rst_ru_last", ru_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_ru_state", ru_state, 128'h0);
    chk("rst_rk_idx", {124'h0, rk_idx}, 128'h0);

    // Stray ru_ack in IDLE changes nothing
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    chk1("stray_ack_idle", busy, 1'b0);

    for (int i = 0; i < 5; i++) run_block(vecs[i], 1'b1);

    // Backpressure in DONE with a new block offered
    run_block(vecs[0], 1'b0);
    y = 128'hfedcba98765432100123456789abcdef;
    in_valid = 1'b1;
    in_data  = y;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_data", out_data, vecs[0].exp);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk1("bp_no_turnaround", busy, 1'b0);
    chk1("bp_idle_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk1("bp_accept_next", busy, 1'b1);
    wait_out(n);
    chk("bp_latency", 128'(n), 128'(NR));
    chk("bp_out_data2", out_data, y);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during round 4 with ru_ack high
    unit_mode = 1'b0; key_mode = 2'd1; waits = 0;
    in_data = 128'h0f0e0d0c0b0a09080706050403020100;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (rk_idx != 4'd4 && n < 50) begin
      step();
      n++;
    end
    chk("mid_rst_round4", {124'h0, rk_idx}, 128'h4);
    chk1("mid_rst_req", ru_req, 1'b1);
    chk1("mid_rst_ack", ru_ack, 1'b1);
    rst = 1'b1;
    force_ack = 1'b1;
    step();
    rst = 1'b0;
    force_ack = 1'b0;
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk1("mid_rst_ru_req", ru_req, 1'b0);
    chk("mid_rst_out_data", out_data, 128'h0);
    chk1("mid_rst_busy", busy, 1'b0);
    run_block(vecs[1], 1'b1);

    // NR=14 instance: identity unit, all-zero keys
    in_data14  = 128'h00112233445566778899aabbccddeeff;
    in_valid14 = 1'b1;
    chk1("nr14_in_ready", in_ready14, 1'b1);
    step();
    in_valid14 = 1'b0;
    n = 0;
    while (!out_valid14 && n < 100) begin
      step();
      n++;
    end
    chk("nr14_latency", 128'(n), 128'd14);
    chk("nr14_out_data", out_data14, 128'h00112233445566778899aabbccddeeff);
    chk("nr14_acks", 128'(acks14), 128'd14);
    chk("nr14_last_acks", 128'(last14), 128'd1);
    chk("nr14_last_misplaced", 128'(badlast14), 128'd0);
    out_ready14 = 1'b1;
    step();
    out_ready14 = 1'b0;
    chk1("nr14_idle", in_ready14, 1'b1);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
